// File: rtl/clk_div_monitor.sv
// Gated rising-edge counter for self-testing the divider chain over a fixed clk window.
// Optional range checker on the err output is enabled by defining CLK_DIV_MON_CHECK_EN.
module clk_div_monitor #(
  parameter int unsigned WINDOW_LEN = 256,
  parameter int unsigned COUNT_W    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [3:0]         div_taps,
  input  logic               y_in,
  input  logic [2:0]         sel,
  input  logic               start,
  output logic [COUNT_W-1:0] count,
  output logic               valid,
  output logic               busy,
  output logic               err
);

  localparam int unsigned WinW = $clog2(WINDOW_LEN);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StDone} state_e;

  state_e             state_q;
  logic [2:0]         sel_q;
  logic               arm_q;
  logic [WinW-1:0]    win_cnt_q;
  logic [COUNT_W-1:0] edge_cnt_q;
  logic [4:0]         sync1_q, sync2_q;
  logic               s_d_q;
  logic               sel_sig, rise, last_win, load;
  logic [COUNT_W-1:0] new_cnt;

  // Bit 4 carries Y, bits 3:0 the divider taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= {y_in, div_taps};
      sync2_q <= sync1_q;
      s_d_q   <= sel_sig;
    end
  end

  always_comb begin
    sel_sig = 1'b0;
    case (sel_q)
      3'd0:    sel_sig = sync2_q[0];
      3'd1:    sel_sig = sync2_q[1];
      3'd2:    sel_sig = sync2_q[2];
      3'd3:    sel_sig = sync2_q[3];
      3'd4:    sel_sig = sync2_q[4];
      default: sel_sig = 1'b0;
    endcase
  end

  assign rise     = sel_sig & ~s_d_q;
  assign new_cnt  = edge_cnt_q + COUNT_W'(rise);
  assign last_win = (win_cnt_q == WinW'(WINDOW_LEN - 1));
  assign load     = ena && (state_q == StMeasure) && last_win;
  assign busy     = (state_q == StArm) || (state_q == StMeasure);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      arm_q      <= 1'b0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      count      <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!ena) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StArm;
              sel_q   <= sel;
              arm_q   <= 1'b0;
            end
          end
          // Two cycles so stale edges from the previous selection drain out.
          StArm: begin
            edge_cnt_q <= '0;
            win_cnt_q  <= '0;
            arm_q      <= 1'b1;
            if (arm_q) state_q <= StMeasure;
          end
          StMeasure: begin
            edge_cnt_q <= new_cnt;
            win_cnt_q  <= win_cnt_q + 1'b1;
            if (last_win) begin
              state_q <= StDone;
              count   <= new_cnt;
              valid   <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef CLK_DIV_MON_CHECK_EN
  localparam logic [COUNT_W:0] One = 1;
  logic [COUNT_W:0] exp_cnt, got_cnt;
  logic             err_q;

  always_comb begin
    exp_cnt = (COUNT_W + 1)'(WINDOW_LEN >> (32'(sel_q) + 32'd1));
    got_cnt = {1'b0, new_cnt};
  end

  // Tolerate +/-1 for phase alignment of the tap against the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load) begin
      err_q <= (sel_q < 3'd4) && ((got_cnt > exp_cnt + One) || (got_cnt + One < exp_cnt));
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
